mem_arbiter: RTL and testbench

Shares one port of the dual-port `memory` block between `NREQ` requesters using a valid/ready request channel and a fixed-latency read response channel. The block sits in front of port A (or B) of `memory`. It performs one grant per cycle and drives registered address, write-enable and write-data into the memory port. It tracks each in-flight read so the returned data is steered to the requester that issued it.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 36 +++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for mem_arbiter, its grant picker and its bench.
// The picker variant is selected by MEM_ARB_RR_EN (see mem_arb_pick).
package mem_arbiter_pkg;

   localparam int NREQ_MAX = 8;

   function automatic int idw_f(input int nreq);
      return (nreq <= 2) ? 1 : $clog2(nreq);
   endfunction

   // Wide enough for any legal requester count, so one index type serves every build.
   localparam int IDW = idw_f(NREQ_MAX);

   typedef logic [IDW-1:0] arb_idx_t;

   function automatic arb_idx_t onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
      arb_idx_t idx;
      idx = '0;
      for (int i = 0; i < NREQ_MAX; i++) begin
         if (oh[i]) idx |= arb_idx_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker: round-robin from ptr when MEM_ARB_RR_EN is defined,
// fixed lowest-index priority otherwise.
module mem_arb_pick
   import mem_arbiter_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] req,
`ifdef MEM_ARB_RR_EN
   input  arb_idx_t        ptr,
`endif
   output logic [NREQ-1:0] gnt,
   output arb_idx_t        gnt_idx
);

`ifdef MEM_ARB_RR_EN
   logic [NREQ-1:0] below_ptr;
   logic [NREQ-1:0] upper_req;
   logic [NREQ-1:0] src_req;

   // Requests at or above ptr win first; otherwise wrap to the lowest index.
   always_comb begin
      below_ptr = (NREQ'(1) << ptr) - NREQ'(1);
      upper_req = req & ~below_ptr;
      src_req   = (|upper_req) ? upper_req : req;
      gnt       = src_req & (~src_req + NREQ'(1));
      gnt_idx   = onehot_to_idx(NREQ_MAX'(gnt));
   end
`else
   always_comb begin
      gnt     = req & (~req + NREQ'(1));
      gnt_idx = onehot_to_idx(NREQ_MAX'(gnt));
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates NREQ requesters onto one synchronous-read memory port and steers read
// data back to the issuer two cycles after the grant. MEM_ARB_RR_EN selects round-robin.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR = 4,
   parameter int DATA = 8,
   parameter int NREQ = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 arb_en,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ-1:0]      req_wr,
   input  logic [NREQ*ADDR-1:0] req_addr,
   input  logic [NREQ*DATA-1:0] req_wdata,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [DATA-1:0]      rsp_rdata,
   output logic                 mem_wr,
   output logic [ADDR-1:0]      mem_addr,
   output logic [DATA-1:0]      mem_din,
   input  logic [DATA-1:0]      mem_dout
);

   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] gnt;
   arb_idx_t        gnt_idx;
   logic            hs;

   logic            sel_wr;
   logic [ADDR-1:0] sel_addr;
   logic [DATA-1:0] sel_wdata;

   logic            mem_wr_q,   mem_wr_d;
   logic [ADDR-1:0] mem_addr_q, mem_addr_d;
   logic [DATA-1:0] mem_din_q,  mem_din_d;
   logic            iss_vld_q,  iss_vld_d;
   logic            iss_rd_q,   iss_rd_d;
   arb_idx_t        iss_id_q,   iss_id_d;
   logic            rsp_vld_q,  rsp_vld_d;
   arb_idx_t        rsp_id_q,   rsp_id_d;

`ifdef MEM_ARB_RR_EN
   arb_idx_t        ptr_q, ptr_d;
`endif

   // Requests are masked during reset so req_ready stays low while rst_n is asserted.
   assign elig = req_valid & {NREQ{arb_en & rst_n}};

   mem_arb_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req     (elig),
`ifdef MEM_ARB_RR_EN
      .ptr     (ptr_q),
`endif
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = gnt;
   assign hs        = |gnt;

   // NOTE: every variable written in an always_comb gets a default first, so no path
   // through the block can leave it unassigned and infer a latch.
   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_wr    = req_wr[i];
            sel_addr  = req_addr[i*ADDR +: ADDR];
            sel_wdata = req_wdata[i*DATA +: DATA];
         end
      end
   end

   always_comb begin
      mem_wr_d   = hs & sel_wr;
      mem_addr_d = hs ? sel_addr  : mem_addr_q;
      mem_din_d  = hs ? sel_wdata : mem_din_q;
      iss_vld_d  = hs;
      iss_rd_d   = hs & ~sel_wr;
      iss_id_d   = hs ? gnt_idx : iss_id_q;
      rsp_vld_d  = iss_vld_q & iss_rd_q;
      rsp_id_d   = iss_id_q;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge value of its inputs regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_wr_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         iss_vld_q  <= 1'b0;
         iss_rd_q   <= 1'b0;
         iss_id_q   <= '0;
         rsp_vld_q  <= 1'b0;
         rsp_id_q   <= '0;
      end else begin
         mem_wr_q   <= mem_wr_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         iss_vld_q  <= iss_vld_d;
         iss_rd_q   <= iss_rd_d;
         iss_id_q   <= iss_id_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_id_q   <= rsp_id_d;
      end
   end

`ifdef MEM_ARB_RR_EN
   always_comb begin
      ptr_d = ptr_q;
      if (hs) begin
         ptr_d = (gnt_idx == arb_idx_t'(NREQ - 1)) ? '0 : gnt_idx + arb_idx_t'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
`endif

   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;
   assign rsp_valid = rsp_vld_q ? (NREQ'(1) << rsp_id_q) : '0;
   assign rsp_rdata = mem_dout;

   a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(req_ready));
   a_ready_needs_valid : assert property (@(posedge clk) disable iff (!rst_n)
      (req_ready & ~req_valid) == '0);
   a_rsp_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(rsp_valid));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a random
// phase, all checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int ADDR = 4;
   localparam int DATA = 8;
   localparam int NREQ = 4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 arb_en;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0]      req_wr;
   logic [NREQ*ADDR-1:0] req_addr;
   logic [NREQ*DATA-1:0] req_wdata;
   logic [NREQ-1:0]      rsp_valid;
   logic [DATA-1:0]      rsp_rdata;
   logic                 mem_wr;
   logic [ADDR-1:0]      mem_addr;
   logic [DATA-1:0]      mem_din;
   logic [DATA-1:0]      mem_dout;

   int n_checks = 0;
   int n_pass   = 0;

   mem_arbiter #(
      .ADDR (ADDR),
      .DATA (DATA),
      .NREQ (NREQ)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .arb_en    (arb_en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory port the arbiter drives.
   logic [DATA-1:0] mem_arr [16] = '{default: '0};
   always @(posedge clk) begin
      if (mem_wr) mem_arr[mem_addr] <= mem_din;
      mem_dout <= mem_arr[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- transaction-level model ----------------
   typedef struct {
      bit              vld;
      bit              wr;
      int              id;
      logic [ADDR-1:0] addr;
      logic [DATA-1:0] data;
   } op_t;

   op_t             at_mem;       // operation expected on mem_* this cycle
   op_t             at_rsp;       // read response expected this cycle
   int              ptr;
   logic [ADDR-1:0] last_addr;
   logic [DATA-1:0] last_din;
   logic [DATA-1:0] model_mem [16];
   logic [NREQ-1:0] model_gnt = '0;

   function automatic int model_pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = (p + k) % NREQ;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_cycle();
      int              g;
      logic [NREQ-1:0] exp_rdy;
      logic [NREQ-1:0] exp_rsp;
      if (!rst_n) begin
         check("rst_req_ready", req_ready, '0);
         check("rst_mem_wr",    mem_wr,    '0);
         check("rst_mem_addr",  mem_addr,  '0);
         check("rst_mem_din",   mem_din,   '0);
         check("rst_rsp_valid", rsp_valid, '0);
         at_mem    = '{default: '0};
         at_rsp    = '{default: '0};
         ptr       = 0;
         last_addr = '0;
         last_din  = '0;
         model_gnt = '0;
         return;
      end
`ifdef MEM_ARB_RR_EN
      g = model_pick(req_valid & {NREQ{arb_en}}, ptr);
`else
      g = model_pick(req_valid & {NREQ{arb_en}}, 0);
`endif
      exp_rdy = (g >= 0) ? NREQ'(1) << g : '0;
      exp_rsp = at_rsp.vld ? NREQ'(1) << at_rsp.id : '0;
      check("req_ready", req_ready, exp_rdy);
      check("mem_wr",    mem_wr,    at_mem.vld && at_mem.wr);
      check("mem_addr",  mem_addr,  last_addr);
      check("mem_din",   mem_din,   last_din);
      check("rsp_valid", rsp_valid, exp_rsp);
      if (at_rsp.vld) check("rsp_rdata", rsp_rdata, at_rsp.data);

      if (at_mem.vld && at_mem.wr) model_mem[at_mem.addr] = at_mem.data;
      at_rsp      = '{default: '0};
      at_rsp.vld  = at_mem.vld && !at_mem.wr;
      at_rsp.id   = at_mem.id;
      at_rsp.data = model_mem[at_mem.addr];

      at_mem = '{default: '0};
      if (g >= 0) begin
         at_mem.vld  = 1'b1;
         at_mem.wr   = req_wr[g];
         at_mem.id   = g;
         at_mem.addr = req_addr[g*ADDR +: ADDR];
         at_mem.data = req_wdata[g*DATA +: DATA];
         last_addr   = at_mem.addr;
         last_din    = at_mem.data;
`ifdef MEM_ARB_RR_EN
         ptr = (g + 1) % NREQ;
`endif
      end
      model_gnt = exp_rdy;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
      at_mem = '{default: '0};
      at_rsp = '{default: '0};
      ptr = 0;
      last_addr = '0;
      last_din = '0;
      forever begin
         @(negedge clk);
         model_cycle();
      end
   end

   // ---------------- stimulus ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic wr, input logic [ADDR-1:0] a,
                          input logic [DATA-1:0] d);
      req_valid[i]               = 1'b1;
      req_wr[i]                  = wr;
      req_addr[i*ADDR +: ADDR]   = a;
      req_wdata[i*DATA +: DATA]  = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [NREQ-1:0] rr_seq [6];

   initial begin
      rr_seq    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      rst_n     = 1'b0;
      arb_en    = 1'b1;
      req_valid = '0;
      req_wr    = '0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single read after a write from another requester.
      set_req(1, 1'b1, 4'h3, 8'h5A);
      @(negedge clk); check("t1_wr_grant", req_ready, 4'b0010);
      next_cycle(); req_valid = '0; set_req(2, 1'b0, 4'h3, 8'h00);
      @(negedge clk); check("t1_rd_grant", req_ready, 4'b0100);
                      check("t1_no_wr_rsp", rsp_valid, 4'b0000);
      next_cycle(); req_valid = '0;
      @(negedge clk); check("t1_rsp_not_early", rsp_valid, 4'b0000);
      next_cycle();
      @(negedge clk); check("t1_rsp_valid", rsp_valid, 4'b0100);
                      check("t1_rsp_rdata", rsp_rdata, 8'h5A);

      // Read-after-write in consecutive cycles.
      next_cycle(); set_req(0, 1'b1, 4'hF, 8'hC3);
      @(negedge clk); check("raw_wr_grant", req_ready, 4'b0001);
      next_cycle(); req_valid = '0; set_req(1, 1'b0, 4'hF, 8'h00);
      @(negedge clk); check("raw_rd_grant", req_ready, 4'b0010);
      next_cycle(); req_valid = '0;
      next_cycle();
      @(negedge clk); check("raw_rsp_valid", rsp_valid, 4'b0010);
                      check("raw_rsp_rdata", rsp_rdata, 8'hC3);

      // arb_en gating with a read still in flight.
      next_cycle(); set_req(3, 1'b0, 4'hF, 8'h00);
      @(negedge clk); check("en_grant", req_ready, 4'b1000);
      next_cycle(); arb_en = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, ADDR'(i), 8'h00);
      @(negedge clk); check("en_block_n1", req_ready, 4'b0000);
      next_cycle();
      @(negedge clk); check("en_block_n2", req_ready, 4'b0000);
                      check("en_rsp_valid", rsp_valid, 4'b1000);
                      check("en_rsp_rdata", rsp_rdata, 8'hC3);
      next_cycle(); req_valid = '0; arb_en = 1'b1;

      // Reset pulse the cycle after a read handshake.
      set_req(1, 1'b0, 4'h5, 8'h77);
      @(negedge clk); check("rst_pre_grant", req_ready, 4'b0010);
      next_cycle(); rst_n = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, ADDR'(i), 8'h00);
      @(negedge clk); check("rst_mid_ready", req_ready, 4'b0000);
                      check("rst_mid_addr",  mem_addr,  4'h0);
                      check("rst_mid_din",   mem_din,   8'h00);
                      check("rst_mid_rsp",   rsp_valid, 4'b0000);
      next_cycle(); rst_n = 1'b1; req_valid = '0;
      @(negedge clk); check("rst_rsp_dropped", rsp_valid, 4'b0000);
      next_cycle();
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, ADDR'(i + 8), 8'h00);

`ifdef MEM_ARB_RR_EN
      // Continuous contention: rotation 0,1,2,3,0,1 from a freshly reset pointer.
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rr_grant", req_ready, rr_seq[k]);
         check("rr_grant_idx", onehot_to_idx(NREQ_MAX'(req_ready)), k % NREQ);
         if (k >= 2) check("rr_rsp", rsp_valid, rr_seq[k-2]);
         next_cycle();
      end
      req_valid = '0;
`else
      @(negedge clk); check("rst_next_grant", req_ready, rr_seq[0]);
      next_cycle(); req_valid = 4'b0101;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); check("fp_hold_0", req_ready, 4'b0001);
         next_cycle();
      end
      req_valid[0] = 1'b0;
      @(negedge clk); check("fp_switch_2", req_ready, 4'b0100);
      next_cycle(); req_valid = '0;
`endif

      // Random traffic, checked by the model every cycle.
      for (int c = 0; c < 600; c++) begin
         next_cycle();
         arb_en = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || model_gnt[i]) begin
               req_valid[i]              = ($urandom_range(0, 2) != 0);
               req_wr[i]                 = 1'($urandom_range(0, 1));
               req_addr[i*ADDR +: ADDR]  = ADDR'($urandom);
               req_wdata[i*DATA +: DATA] = DATA'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
      end

      next_cycle(); req_valid = '0; arb_en = 1'b1;
      repeat (4) next_cycle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
